muldiv_unit: RTL
================

Name: muldiv_unit

Overview:
- Multiply/divide unit in the EX stage of the P7 five-stage MIPS pipeline.
- Consumes the ID-stage decode outputs `start`, `MDCCtrl`, `MDM_WE` and `MDM_RE` after they pass through the ID/EX register.
- Owns the HI/LO registers and models multi-cycle mult/div latency with a busy counter.
- ID-stage hazard logic stalls any muldiv-class instruction while `busy` is high or `start` is high.

Parameters:
- MULT_CYCLES, 5, busy duration in cycles for mult/multu/madd.
- DIV_CYCLES, 10, busy duration in cycles for div/divu.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset (low = reset asserted).
- start  input  1  launch the operation selected by MDCCtrl this cycle.
- MDCCtrl  input  3  000 mult, 001 multu, 010 div, 011 divu, 100 madd; other codes launch nothing.
- MDM_WE  input  2  01 mthi, 10 mtlo, 00/11 no write.
- MDM_RE  input  2  01 read HI, 10 read LO, 00/11 read zero.
- req  input  1  exception/interrupt taken this cycle; squashes this cycle's start and MDM_WE.
- A  input  32  rs operand (forwarded).
- B  input  32  rt operand (forwarded).
- busy  output  1  operation in flight.
- out  output  32  combinational read data.
- HI  output  32  architectural HI.
- LO  output  32  architectural LO.

Behaviour:
- Reset (reset low, asynchronous): HI=0, LO=0, busy=0, counter=0, pending results=0. This applies mid-operation too; an in-flight result is discarded.
- State: IDLE (counter=0) / RUN (counter>0). busy is registered and equals (counter!=0).
- Launch: accepted at a rising edge when start=1, req=0, busy=0 and MDCCtrl is valid.
  - Operands are sampled at that edge.
  - 64-bit result is computed into internal tHI/tLO.
  - counter is loaded with MULT_CYCLES or DIV_CYCLES.
- busy is high for exactly N cycles, starting the cycle after launch.
- Completion: at the edge where counter goes 1→0, HI<=tHI and LO<=tLO; busy reads 0 in the following cycle.
- HI/LO are architecturally unchanged while busy=1.
- start while busy=1: ignored. Hazard logic prevents it; the bench checks the ignore anyway.
- Arithmetic:
  - mult: {HI,LO} = signed(A)*signed(B).
  - multu: {HI,LO} = unsigned(A)*unsigned(B).
  - madd: {HI,LO} = {HI,LO} + signed(A)*signed(B), modulo 2^64, using HI/LO as of launch.
  - div: LO = quotient truncated toward zero; HI = remainder, same sign as A.
  - divu: unsigned quotient and remainder.
  - Divisor B=0 (div/divu): busy sequence runs normally; HI/LO are left unchanged at completion.
  - div with A=0x80000000, B=0xFFFFFFFF: LO=0x80000000, HI=0.
- mthi/mtlo: when MDM_WE!=00, req=0, busy=0 and start=0, HI or LO <= A at the edge; visible the next cycle.
  - MDM_WE while busy: ignored.
  - MDM_WE with start in the same cycle: start wins, write dropped. Decode makes these exclusive.
- req=1: this cycle's start and MDM_WE have no effect. An operation already in RUN continues and completes.
- out: purely combinational.
  - MDM_RE=01 → HI; 10 → LO; else 0.
  - Reads the registered HI/LO. No bypass of same-cycle writes or of pending results.
- counter width: enough for max(MULT_CYCLES, DIV_CYCLES). Both parameters must be ≥1.

Test Plan:
- Reset low mid-div (counter=4) → busy=0, HI=LO=0 immediately (asynchronous), no later update after reset is released.
- mult A=0xFFFFFFFE(-2), B=3 → busy high for exactly 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFA. multu with the same operands → HI=0x00000002, LO=0xFFFFFFFA.
- div A=0xFFFFFFF9(-7), B=2 → busy high for exactly 10 cycles; LO=0xFFFFFFFD, HI=0xFFFFFFFF. divu A=7, B=0 → HI/LO unchanged after 10 busy cycles.
- mthi A=0x12345678, then mtlo A=0x1, then madd A=2, B=3 → after 5 cycles HI=0x12345678, LO=0x7; MDM_RE=01 gives out=0x12345678, MDM_RE=10 gives out=0x7, MDM_RE=00 gives out=0.
- start with req=1 (mult 3×3), and mtlo with req=1 → busy stays 0, HI/LO unchanged. A req asserted during a running mult does not stop its completion.
- start and mthi attempted while busy=1 → ignored; results equal those of the original operation alone; busy drops on schedule.

Source files
------------

// File: rtl/muldiv_unit.sv
// muldiv_unit: HI/LO multiply-divide unit with fixed multi-cycle busy latency
module muldiv_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  MDCCtrl,
  input  logic [1:0]  MDM_WE,
  input  logic [1:0]  MDM_RE,
  input  logic        req,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic [31:0] out,
  output logic [31:0] HI,
  output logic [31:0] LO
);
  localparam int MAXC = MULT_CYCLES > DIV_CYCLES ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW = $clog2(MAXC + 1);
  logic [31:0] hi_q, hi_d, lo_q, lo_d, thi_q, thi_d, tlo_q, tlo_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic busy_q, launch, is_div, sgn, wr_ok;
  logic [63:0] prod, res;
  logic signed [32:0] dvd, dvs;
  logic [31:0] quo, rem;
  always_comb begin
    launch = start & ~req & ~busy_q & (MDCCtrl <= 3'd4);
    wr_ok = ~start & ~req & ~busy_q;
    is_div = MDCCtrl[2:1] == 2'b01;
    sgn = ~MDCCtrl[0];
    prod = {{32{sgn & A[31]}}, A} * {{32{sgn & B[31]}}, B};
    // 33-bit signed divide covers both signednesses and the -2^31 / -1 case
    dvd = {sgn & A[31], A};
    dvs = B == 32'd0 ? 33'sd1 : {sgn & B[31], B};
    quo = 32'(dvd / dvs);
    rem = 32'(dvd % dvs);
    res = MDCCtrl[2] ? {hi_q, lo_q} + prod : !is_div ? prod : B == 32'd0 ? {hi_q, lo_q} : {rem, quo};
    cnt_d = launch ? CW'(is_div ? DIV_CYCLES : MULT_CYCLES) : cnt_q - CW'(cnt_q != '0);
    thi_d = launch ? res[63:32] : thi_q;
    tlo_d = launch ? res[31:0] : tlo_q;
    hi_d = cnt_q == CW'(1) ? thi_q : (wr_ok && MDM_WE == 2'b01) ? A : hi_q;
    lo_d = cnt_q == CW'(1) ? tlo_q : (wr_ok && MDM_WE == 2'b10) ? A : lo_q;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hi_q <= '0;
      lo_q <= '0;
      thi_q <= '0;
      tlo_q <= '0;
      cnt_q <= '0;
      busy_q <= 1'b0;
    end else begin
      hi_q <= hi_d;
      lo_q <= lo_d;
      thi_q <= thi_d;
      tlo_q <= tlo_d;
      cnt_q <= cnt_d;
      busy_q <= cnt_d != '0;
    end
  end
  assign busy = busy_q;
  assign HI = hi_q;
  assign LO = lo_q;
  assign out = MDM_RE == 2'b01 ? hi_q : MDM_RE == 2'b10 ? lo_q : 32'd0;
endmodule
